alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-entry issue controller in front of a combinational ALU.
// It accepts one request, decodes it into an ALU control code, and holds the
// registered operands and control for one EXEC cycle. It then captures the
// ALU result and zero flag, and holds the response until the consumer takes it.
// A request presented while IDLE is sampled at edge N+1. rsp_valid is high
// after edge N+2, so at most one operation completes every three cycles.
//
// Optional feature: define ALU_SLT_EN to decode R-type funct3=010 as a signed
// set-less-than (the ALU subtracts, and the result is built from the sign bits).
// Without the macro, that encoding is reported as illegal.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_aluop,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7b5,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  ALUControl_out,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] ALU_result_in,
  input  logic        zero_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_PASS = 4'b1111;

  state_t      state_q, state_d;

  logic        accept;
  logic [3:0]  dec_ctrl;
  logic        dec_illegal;

  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        illegal_q, illegal_d;

  logic [31:0] rsp_result_q, rsp_result_d;
  logic        rsp_zero_q, rsp_zero_d;
  logic        rsp_illegal_q, rsp_illegal_d;

`ifdef ALU_SLT_EN
  logic        dec_slt;
  logic        slt_q, slt_d;
`endif

  assign accept = (state_q == IDLE) && req_valid;

  // Decode the request fields into an ALU control code and an illegal flag.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path can infer a latch.
    dec_ctrl    = CTRL_PASS;
    dec_illegal = 1'b1;
`ifdef ALU_SLT_EN
    dec_slt     = 1'b0;
`endif
    case (req_aluop)
      2'b00: begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_ctrl    = CTRL_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        case (req_funct3)
          3'b000: begin
            dec_ctrl    = req_funct7b5 ? CTRL_SUB : CTRL_ADD;
            dec_illegal = 1'b0;
          end
          3'b111: begin
            dec_ctrl    = CTRL_AND;
            dec_illegal = 1'b0;
          end
          3'b110: begin
            dec_ctrl    = CTRL_OR;
            dec_illegal = 1'b0;
          end
`ifdef ALU_SLT_EN
          3'b010: begin
            dec_ctrl    = CTRL_SUB;
            dec_illegal = 1'b0;
            dec_slt     = 1'b1;
          end
`endif
          default: begin
            dec_ctrl    = CTRL_PASS;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = CTRL_PASS;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC for one cycle, RESP until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on the current state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Issue registers load on accept and otherwise hold their last values.
  always_comb begin
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    illegal_d = illegal_q;
`ifdef ALU_SLT_EN
    slt_d     = slt_q;
`endif
    if (accept) begin
      ctrl_d    = dec_ctrl;
      a_d       = req_a;
      b_d       = req_b;
      illegal_d = dec_illegal;
`ifdef ALU_SLT_EN
      slt_d     = dec_slt;
`endif
    end
  end

  // Issue register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= CTRL_AND;
      a_q       <= '0;
      b_q       <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_SLT_EN
      slt_q     <= 1'b0;
`endif
    end else begin
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      illegal_q <= illegal_d;
`ifdef ALU_SLT_EN
      slt_q     <= slt_d;
`endif
    end
  end

  // Response capture at the end of EXEC. Illegal ops return operand A with
  // zero forced low; SLT builds its bit from the operand signs and the SUB sign.
  always_comb begin
    rsp_result_d  = rsp_result_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    if (state_q == EXEC) begin
      rsp_illegal_d = illegal_q;
      if (illegal_q) begin
        rsp_result_d = a_q;
        rsp_zero_d   = 1'b0;
`ifdef ALU_SLT_EN
      end else if (slt_q) begin
        rsp_result_d = {31'b0, (a_q[31] ^ b_q[31]) ? a_q[31] : ALU_result_in[31]};
        rsp_zero_d   = 1'b0;
`endif
      end else begin
        rsp_result_d = ALU_result_in;
        rsp_zero_d   = zero_in;
      end
    end
  end

  // Response register update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      rsp_result_q  <= rsp_result_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign ALUControl_out = ctrl_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_illegal    = rsp_illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives the result
// inputs, and an instruction-level reference model predicts every response.
// Honours ALU_SLT_EN in the same way as the design.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_aluop;
  logic [2:0]  req_funct3;
  logic        req_funct7b5;
  logic [31:0] req_a, req_b;
  logic [3:0]  ALUControl_out;
  logic [31:0] alu_a, alu_b;
  logic [31:0] ALU_result_in;
  logic        zero_in;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_aluop     (req_aluop),
    .req_funct3    (req_funct3),
    .req_funct7b5  (req_funct7b5),
    .req_a         (req_a),
    .req_b         (req_b),
    .ALUControl_out(ALUControl_out),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .ALU_result_in (ALU_result_in),
    .zero_in       (zero_in),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_zero      (rsp_zero),
    .rsp_illegal   (rsp_illegal)
  );

  // Behavioural ALU seen by the controller.
  always_comb begin
    case (ALUControl_out)
      4'b0000: ALU_result_in = alu_a & alu_b;
      4'b0001: ALU_result_in = alu_a | alu_b;
      4'b0010: ALU_result_in = alu_a + alu_b;
      4'b0110: ALU_result_in = alu_a - alu_b;
      4'b1111: ALU_result_in = alu_a;
      default: ALU_result_in = 32'hDEAD_BEEF;
    endcase
    zero_in = (ALU_result_in == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction-level reference: what the operation means, not how it is decoded.
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [3:0] ctrl, output logic [31:0] res,
                       output logic zero, output logic ill);
    bit is_slt;
    ill    = 1'b0;
    is_slt = 1'b0;
    ctrl   = 4'b1111;
    res    = a;
    if (op == 2'b00)                    begin ctrl = 4'b0010; res = a + b; end
    else if (op == 2'b01)               begin ctrl = 4'b0110; res = a - b; end
    else if (op == 2'b10 && f3 == 3'd0) begin
      ctrl = f7 ? 4'b0110 : 4'b0010;
      res  = f7 ? a - b : a + b;
    end
    else if (op == 2'b10 && f3 == 3'd7) begin ctrl = 4'b0000; res = a & b; end
    else if (op == 2'b10 && f3 == 3'd6) begin ctrl = 4'b0001; res = a | b; end
`ifdef ALU_SLT_EN
    else if (op == 2'b10 && f3 == 3'd2) begin
      ctrl = 4'b0110; is_slt = 1'b1;
      res  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end
`endif
    else ill = 1'b1;
    zero = (ill || is_slt) ? 1'b0 : (res == 32'd0);
  endtask

  task automatic drive_idle_garbage();
    req_aluop    = 2'($urandom);
    req_funct3   = 3'($urandom);
    req_funct7b5 = 1'($urandom);
    req_a        = $urandom;
    req_b        = $urandom;
  endtask

  // Issue one op, check EXEC, hold RESP for 'hold' cycles, release, check IDLE.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [3:0]  e_ctrl;
    logic [31:0] e_res;
    logic        e_zero, e_ill;
    model(op, f3, f7, a, b, e_ctrl, e_res, e_zero, e_ill);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_aluop = op; req_funct3 = f3; req_funct7b5 = f7;
    req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    drive_idle_garbage();
    check("exec_ctrl", 32'(ALUControl_out), 32'(e_ctrl));
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    // A request offered during RESP must not be taken on the release edge.
    req_valid = 1'b1;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); #1; end
      check("resp_valid", 32'(rsp_valid), 32'd1);
      check("resp_req_ready", 32'(req_ready), 32'd0);
      check("resp_result", rsp_result, e_res);
      check("resp_zero", 32'(rsp_zero), 32'(e_zero));
      check("resp_illegal", 32'(rsp_illegal), 32'(e_ill));
      check("resp_ctrl_hold", 32'(ALUControl_out), 32'(e_ctrl));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("back_idle_rsp_valid", 32'(rsp_valid), 32'd0);
    check("back_idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_alu_a_hold", alu_a, a);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rsp_result"}, rsp_result, 32'd0);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
    check({tag, "_ctrl"}, 32'(ALUControl_out), 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
  endtask

  // Start an op and reset it during EXEC (stage 0) or RESP (stage 1).
  task automatic reset_in_flight(input int stage);
    req_valid = 1'b1; req_aluop = 2'b01; req_funct3 = 3'd0; req_funct7b5 = 1'b0;
    req_a = 32'h55; req_b = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (stage == 1) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check_reset_state(stage == 0 ? "rst_exec" : "rst_resp");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_response", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    drive_idle_garbage();
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_state("post_reset");

    // Directed cases.
    run_op(2'b00, 3'd0, 1'b0, 32'h10, 32'h4, 0);
    run_op(2'b01, 3'd0, 1'b0, 32'h55, 32'h55, 0);
    run_op(2'b01, 3'd0, 1'b0, 32'h55, 32'h54, 1);
    run_op(2'b10, 3'd7, 1'b0, 32'hF0F0, 32'h0FF0, 0);
    run_op(2'b10, 3'd6, 1'b0, 32'hF0F0, 32'h0FF0, 5);
    run_op(2'b10, 3'd0, 1'b1, 32'h7, 32'h9, 0);
    run_op(2'b10, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(2'b10, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(2'b10, 3'd2, 1'b0, 32'h1, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 3'd2, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op(2'b11, 3'd0, 1'b0, 32'h1234, 32'h0, 0);
    run_op(2'b10, 3'd1, 1'b0, 32'hABCD, 32'h0, 0);

    reset_in_flight(0);
    reset_in_flight(1);
    run_op(2'b00, 3'd0, 1'b0, 32'h1, 32'h2, 0);

    // Randomized traffic, biased towards equal operands to exercise zero.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom),
             ra, rb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
